// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//
// Shared definitions for the instruction-fetch front end:
//   DEFAULT_XLEN / DEFAULT_ILEN   default PC and instruction widths
//   INSTR_BYTES                   bytes per instruction (PC step)
//   DEFAULT_RESET_VECTOR          default PC after reset
//   fetch_entry_t                 {pc, instr} pair at the default widths
//   word_align()                  clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int DEFAULT_XLEN = 32;
    localparam int DEFAULT_ILEN = 32;
    localparam int INSTR_BYTES  = 4;

    localparam logic [DEFAULT_XLEN-1:0] DEFAULT_RESET_VECTOR = '0;

    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] pc;
        logic [DEFAULT_ILEN-1:0] instr;
    } fetch_entry_t;

    // Clears the low-order byte-offset bits so the result is instruction aligned.
    function automatic logic [DEFAULT_XLEN-1:0] word_align(input logic [DEFAULT_XLEN-1:0] addr);
        return addr & ~DEFAULT_XLEN'(INSTR_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//
// Synchronous FIFO holding fetched {pc, instr} entries between the fetch
// stage and decode. The head entry is read straight from registered storage,
// so the consumer sees a glitch-free value that is stable until popped.
//
// Parameters:
//   FIFO_DEPTH  number of entries, power of two, >= 2
//   entry_t     stored entry type
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (control state only)
//   push   write din at the tail this edge
//   pop    remove the head entry this edge
//   flush  discard every entry this edge; wins over push and pop
//   din    entry to write
//   full   count == FIFO_DEPTH
//   empty  count == 0
//   count  occupied entries
//   head   oldest entry (undefined while empty)
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  FIFO_DEPTH = 4,
    parameter type entry_t    = fetch_entry_t
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  entry_t                        din,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output entry_t                        head
);

    localparam int AW = $clog2(FIFO_DEPTH);

    entry_t          mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count_r;
    logic            do_push;
    logic            do_pop;

    // Depth is a power of two, so the count MSB alone marks "full".
    assign full  = count_r[AW];
    assign empty = (count_r == '0);
    assign count = count_r;
    assign head  = mem[rd_ptr];

    // Never pop an empty FIFO; a push on a full FIFO is only legal alongside a pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage is data only; stale contents are never visible because the
    // pointers and count are cleared on reset and flush.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch front end. Owns the program counter, issues one aligned
// address per cycle to a combinational-read instruction memory, buffers the
// fetched {pc, instr} pairs and presents them to decode over valid/ready.
// A redirect loads a new PC and flushes the buffer; reset overrides redirect.
//
// Optional build macro:
//   FETCH_BYPASS_EN  when defined, an instruction fetched while the buffer is
//                    empty is presented to decode in the same cycle; if decode
//                    accepts it the entry is not written into the buffer.
//
// Parameters:
//   XLEN          PC / address width
//   ILEN          instruction width
//   RESET_VECTOR  PC after reset (multiple of 4)
//   FIFO_DEPTH    fetch buffer entries (power of two, >= 2)
//
// Ports:
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset
//   redirect_valid  load redirect_pc and flush the buffer at this edge
//   redirect_pc     new fetch address, low two bits ignored
//   imem_addr       fetch address (current PC)
//   imem_req        a fetch is issued this cycle
//   imem_instr      combinational read data for imem_addr
//   out_valid       out_pc / out_instr hold a valid entry
//   out_ready       decode accepts the presented entry
//   out_pc          PC of the presented instruction (0 when nothing valid)
//   out_instr       presented instruction (0 when nothing valid)
//   fifo_count      occupied buffer entries
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN         = DEFAULT_XLEN,
    parameter int              ILEN         = DEFAULT_ILEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter int              FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic [XLEN-1:0]               imem_addr,
    output logic                          imem_req,
    input  logic [ILEN-1:0]               imem_instr,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [XLEN-1:0]               out_pc,
    output logic [ILEN-1:0]               out_instr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] redirect_target;
    entry_t          push_entry;
    entry_t          head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;
    logic            head_pop;

    assign imem_addr       = fetch_pc;
    assign redirect_target = redirect_pc & ~XLEN'(INSTR_BYTES - 1);
    assign push_entry      = '{pc: fetch_pc, instr: imem_instr};

    // Decode takes the buffered head. A full buffer still accepts a fetch when
    // the head leaves in the same cycle, which keeps one instr/cycle flowing.
    assign head_pop = ~fifo_empty & out_ready;
    assign imem_req = ~redirect_valid & (~fifo_full | head_pop);

`ifdef FETCH_BYPASS_EN
    logic bypass_hit;

    // With an empty buffer the fetched word is forwarded straight to decode.
    assign bypass_hit = fifo_empty & imem_req;

    always_comb begin
        out_valid = ~fifo_empty | bypass_hit;
        out_pc    = '0;
        out_instr = '0;
        if (!fifo_empty) begin
            out_pc    = head.pc;
            out_instr = head.instr;
        end else if (bypass_hit) begin
            out_pc    = fetch_pc;
            out_instr = imem_instr;
        end
    end

    // A forwarded word that decode accepts is consumed and never buffered.
    assign fifo_push = imem_req & ~(bypass_hit & out_ready);
    assign fifo_pop  = head_pop;
`else
    always_comb begin
        out_valid = ~fifo_empty;
        out_pc    = '0;
        out_instr = '0;
        if (!fifo_empty) begin
            out_pc    = head.pc;
            out_instr = head.instr;
        end
    end

    assign fifo_push = imem_req;
    assign fifo_pop  = head_pop;
`endif

    // Program counter: reset beats redirect, redirect beats sequential fetch.
    // The increment wraps naturally at 2^XLEN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_VECTOR;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_target;
        end else if (imem_req) begin
            fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
        end
    end

    // Fetch buffer; a redirect flushes it, including an entry popped this cycle.
    fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .entry_t    (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (redirect_valid),
        .din   (push_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (head)
    );

endmodule
